seq_chunk_adder: RTL and testbench
==================================

// Module: seq_chunk_adder
// PURPOSE
//  Multi-cycle, parametrised add/subtract unit built from a CHUNK-bit ripple-carry slice.
//  Adds one chunk per cycle, LSB first, and registers the carry between cycles.
//  Trades latency for a short critical path in wide datapaths (ALU add/sub, address calc).
//  Operands enter on a valid/ready handshake; the result leaves on a second handshake with flags.
// PARAMETERS
//  WIDTH   32  operand/result width in bits
//  CHUNK   8   bits added per cycle; WIDTH % CHUNK != 0 is an elaboration error
//  (derived) NCHUNK = WIDTH/CHUNK   number of cycles spent in RUN
// PORTS
//  clock      in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      operands/mode valid
//  in_ready   out  1      unit can accept an operation
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (ignored when sub=1)
//  sub        in   1      0: a+b+cin   1: a+~b+1 (a-b)
//  out_valid  out  1      result and flags valid
//  out_ready  in   1      consumer takes the result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//  overflow   out  1      signed overflow = carry into MSB ^ carry out of MSB
//  zero       out  1      sum == 0
// BEHAVIOUR
//  Reset (edge with reset=1): state=IDLE; sum=0, cout=0, overflow=0, zero=0, out_valid=0,
//   chunk index=0. Any in-flight operation is discarded; reset wins over every other input.
//  in_ready = (state==IDLE) && !reset. out_valid = (state==DONE). Neither depends on in_valid.
//  FSM:
//   IDLE: in_valid&&in_ready -> latch a, b^{WIDTH{sub}}, carry=sub?1:cin; idx=0 -> RUN
//   RUN : each cycle add chunk idx using the registered carry; write sum[idx*CHUNK +: CHUNK];
//         update carry; idx++. Chunk NCHUNK-1 also captures the carry into the MSB
//         -> update cout, overflow, zero -> DONE
//   DONE: hold all outputs. out_ready=1 -> IDLE. out_ready=0 -> stay (back-pressure).
//  Latency: accept at edge t; out_valid=1 from the cycle after edge t+NCHUNK.
//   Throughput: one operation every NCHUNK+2 cycles at best.
//  No overlap: in_valid is ignored outside IDLE. The DONE->IDLE edge does not also accept.
//  sum/cout/overflow/zero are stable from out_valid until the next accept.
//   They may change during RUN; consumers must qualify them with out_valid.
//  CHUNK==WIDTH: NCHUNK=1, a single RUN cycle. Carry propagates across every chunk boundary.
//  sub=1 ignores cin. Operands are sampled only on the accept edge; later changes on a/b have no effect.
// TESTING (WIDTH=32, CHUNK=8)
//  a=0x000000FF b=1 cin=0 sub=0 -> sum=0x00000100 cout=0 ovf=0 zero=0; out_valid exactly 4 cycles after accept
//  a=0xFFFFFFFF b=0 cin=1 sub=0 -> sum=0 cout=1 zero=1 ovf=0 (carry ripples through all 4 chunks)
//  a=0x7FFFFFFF b=1 sub=0 -> sum=0x80000000 ovf=1 cout=0; a=5 b=5 sub=1 cin=0 -> sum=0 zero=1 cout=1
//  a=3 b=5 sub=1 -> sum=0xFFFFFFFE cout=0 ovf=0; out_ready=0 for 10 cycles -> out_valid, sum held, in_ready=0, in_valid ignored
//  reset=1 in 2nd RUN cycle -> next cycle out_valid=0 in_ready=1 sum=0; following op a=1 b=2 -> sum=3
//  Random: 1000 ops with random in_valid/out_ready gaps vs {cout,sum}=a+(sub?~b:b)+(sub|cin); check flags

Source files
------------

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// Producer/consumer side uses master; the adder uses slave.
interface seq_chunk_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, overflow, zero
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, overflow, zero
   );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/sub: one CHUNK-bit ripple slice per cycle, LSB first,
// carry registered between cycles; results leave on a valid/ready handshake.
module seq_chunk_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clock,
   input  logic             reset,
   seq_chunk_adder_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   generate
      if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   int               w_base;
   logic [CHUNK-1:0] w_ach;
   logic [CHUNK-1:0] w_bch;
   logic [CHUNK:0]   w_add;
   logic             w_msb_cin;
   logic [WIDTH-1:0] w_sum_nxt;
   logic             w_last;

   always_comb begin
      w_base    = int'(r_idx) * CHUNK;
      w_ach     = r_a[w_base +: CHUNK];
      w_bch     = r_b[w_base +: CHUNK];
      w_add     = {1'b0, w_ach} + {1'b0, w_bch}
                + {{CHUNK{1'b0}}, r_carry};
      // Carry into the top bit of this slice; only meaningful on the last chunk
      w_msb_cin = w_ach[CHUNK-1] ^ w_bch[CHUNK-1] ^ w_add[CHUNK-1];
      w_sum_nxt = r_sum;
      w_sum_nxt[w_base +: CHUNK] = w_add[CHUNK-1:0];
      w_last    = (r_idx == LAST);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b ^ {WIDTH{bus.sub}};
                  r_carry <= bus.sub | bus.cin;
                  r_idx   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_sum   <= w_sum_nxt;
               r_carry <= w_add[CHUNK];
               if (w_last) begin
                  r_cout  <= w_add[CHUNK];
                  r_ovf   <= w_msb_cin ^ w_add[CHUNK];
                  r_zero  <= (w_sum_nxt == '0);
                  r_state <= S_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE) && !reset;
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
   assign bus.overflow  = r_ovf;
   assign bus.zero      = r_zero;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed and random checks for seq_chunk_adder (WIDTH=32, CHUNK=8).
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_seq_chunk_adder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   seq_chunk_adder_if #(.WIDTH(32)) bus();

   seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clock(clk),
      .reset(rst),
      .bus  (bus)
   );

   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic s);
      int w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      n_total++;
      if (bus.in_ready !== 1'b1)
         $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
      else
         n_pass++;
      bus.in_valid = 1'b1;
      bus.a = a;
      bus.b = b;
      bus.cin = ci;
      bus.sub = s;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a = ~a;
      bus.b = 32'hDEAD_BEEF;
      bus.cin = ~ci;
      bus.sub = ~s;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      @(negedge clk);
      while (!bus.out_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      n_total++;
      if (bus.out_valid !== 1'b1)
         $display("FAIL done_timeout: out_valid=%b required 1", bus.out_valid);
      else
         n_pass++;
   endtask

   task automatic consume();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_total++;
      if (bus.in_ready !== 1'b0)
         $display("FAIL rst_in_ready_low: got %b required 0", bus.in_ready);
      else n_pass++;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_total++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01)
         $display("FAIL rst_handshake: got %b required 01",
                  {bus.out_valid, bus.in_ready});
      else n_pass++;
      n_total++;
      if ({bus.sum, bus.cout, bus.overflow, bus.zero} !== 35'd0)
         $display("FAIL rst_outputs: sum=%h c=%b v=%b z=%b required 0",
                  bus.sum, bus.cout, bus.overflow, bus.zero);
      else n_pass++;
   endtask

   task automatic test_directed();
      logic [31:0] va [6];
      logic [31:0] vb [6];
      logic        vc [6];
      logic        vs [6];
      logic [31:0] es [6];
      logic [2:0]  ef [6];
      int cyc;
      va[0] = 32'h0000_00FF; vb[0] = 32'h1; vc[0] = 0; vs[0] = 0;
      es[0] = 32'h0000_0100; ef[0] = 3'b000;
      va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0; vc[1] = 1; vs[1] = 0;
      es[1] = 32'h0;         ef[1] = 3'b101;
      va[2] = 32'h7FFF_FFFF; vb[2] = 32'h1; vc[2] = 0; vs[2] = 0;
      es[2] = 32'h8000_0000; ef[2] = 3'b010;
      va[3] = 32'h5;         vb[3] = 32'h5; vc[3] = 0; vs[3] = 1;
      es[3] = 32'h0;         ef[3] = 3'b101;
      va[4] = 32'h3;         vb[4] = 32'h5; vc[4] = 1; vs[4] = 1;
      es[4] = 32'hFFFF_FFFE; ef[4] = 3'b000;
      va[5] = 32'h8000_0000; vb[5] = 32'h1; vc[5] = 0; vs[5] = 1;
      es[5] = 32'h7FFF_FFFF; ef[5] = 3'b110;
      for (int i = 0; i < 6; i++) begin
         send(va[i], vb[i], vc[i], vs[i]);
         wait_done(cyc);
         n_total++;
         if (cyc !== 4)
            $display("FAIL latency[%0d]: got %0d required 4", i, cyc);
         else n_pass++;
         n_total++;
         if (bus.sum !== es[i])
            $display("FAIL sum[%0d]: got %h required %h", i, bus.sum, es[i]);
         else n_pass++;
         n_total++;
         if ({bus.cout, bus.overflow, bus.zero} !== ef[i])
            $display("FAIL flags[%0d]: cvz got %b required %b", i,
                     {bus.cout, bus.overflow, bus.zero}, ef[i]);
         else n_pass++;
         consume();
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      send(32'h3, 32'h5, 1'b0, 1'b1);
      wait_done(cyc);
      bus.in_valid = 1'b1;
      bus.a = 32'h11;
      bus.b = 32'h22;
      bus.sub = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_total++;
         if ({bus.out_valid, bus.in_ready} !== 2'b10)
            $display("FAIL bp_hs[%0d]: ov/ir got %b required 10", i,
                     {bus.out_valid, bus.in_ready});
         else n_pass++;
         n_total++;
         if (bus.sum !== 32'hFFFF_FFFE)
            $display("FAIL bp_sum[%0d]: got %h required fffffffe", i, bus.sum);
         else n_pass++;
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         n_total++;
         if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL bp_no_accept: ov/ir got %b required 01",
                     {bus.out_valid, bus.in_ready});
         else n_pass++;
      end
   endtask

   task automatic test_reset_midrun();
      int cyc;
      send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_total++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01)
         $display("FAIL midrst_hs: ov/ir got %b required 01",
                  {bus.out_valid, bus.in_ready});
      else n_pass++;
      n_total++;
      if (bus.sum !== 32'h0)
         $display("FAIL midrst_sum: got %h required 0", bus.sum);
      else n_pass++;
      send(32'h1, 32'h2, 1'b0, 1'b0);
      wait_done(cyc);
      n_total++;
      if (bus.sum !== 32'h3 || cyc !== 4)
         $display("FAIL midrst_next: sum=%h lat=%0d required 3/4", bus.sum, cyc);
      else n_pass++;
      consume();
   endtask

   task automatic test_random();
      logic [31:0] a, b, bb, sm;
      logic        ci, s, co, ov;
      int cyc;
      for (int i = 0; i < 1000; i++) begin
         a  = $urandom;
         b  = $urandom;
         ci = 1'($urandom_range(0, 1));
         s  = 1'($urandom_range(0, 1));
         if (i % 8 == 0) b = a;
         bb = s ? ~b : b;
         {co, sm} = {1'b0, a} + {1'b0, bb} + {32'd0, s | ci};
         ov = (a[31] == bb[31]) && (sm[31] != a[31]);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(a, b, ci, s);
         wait_done(cyc);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         n_total++;
         if (bus.sum !== sm)
            $display("FAIL rnd_sum[%0d]: got %h required %h", i, bus.sum, sm);
         else n_pass++;
         n_total++;
         if ({bus.cout, bus.overflow, bus.zero} !== {co, ov, sm == 32'd0})
            $display("FAIL rnd_flags[%0d]: cvz got %b required %b", i,
                     {bus.cout, bus.overflow, bus.zero},
                     {co, ov, sm == 32'd0});
         else n_pass++;
         consume();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_midrun();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
